// File: rtl/mult_pipe_cell.sv
`default_nettype none
// ============================================================================
// Module   : mult_pipe_cell
// Brief    : Elastic two-stage DATA_W x DATA_W multiplier with low/high word
//            select and unsigned/signed/mixed operands. Optional accumulator
//            enabled by defining MULT_PIPE_ACC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mult_pipe_cell #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        in_mode,
    input  logic [TAG_W-1:0]  in_tag,
`ifdef MULT_PIPE_ACC_EN
    input  logic              in_acc,
    input  logic              in_acc_clr,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    localparam int c_h  = DATA_W / 2;
    localparam int c_pw = DATA_W + 2;   // (H+1) x (H+1) signed product width
    localparam int c_fw = 2 * DATA_W;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s1_adv;
    logic w_s2_adv;

    assign w_s2_adv  = ~r_s2_valid | out_ready;
    assign w_s1_adv  = ~r_s1_valid | w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign busy      = r_s1_valid | r_s2_valid;

    // ------------------------------------------------------------------
    // Stage 1: half-width partial products
    // ------------------------------------------------------------------
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic [c_pw-1:0]   w_a_lo;
    logic [c_pw-1:0]   w_a_hi;
    logic [c_pw-1:0]   w_b_lo;
    logic [c_pw-1:0]   w_b_hi;
    logic [c_pw-1:0]   w_pp0;
    logic [c_pw-1:0]   w_pp1;
    logic [c_pw-1:0]   w_pp2;
    logic [c_pw-1:0]   w_pp3;

    assign w_a_sgn = in_mode[1];
    assign w_b_sgn = (in_mode == 2'b11);

    // Operands pre-extended to the product width so that the modular
    // multiply yields the exact two's-complement partial product.
    assign w_a_lo = {{(c_h+2){1'b0}}, in_a[c_h-1:0]};
    assign w_b_lo = {{(c_h+2){1'b0}}, in_b[c_h-1:0]};
    assign w_a_hi = {{(c_h+2){w_a_sgn & in_a[DATA_W-1]}}, in_a[DATA_W-1:c_h]};
    assign w_b_hi = {{(c_h+2){w_b_sgn & in_b[DATA_W-1]}}, in_b[DATA_W-1:c_h]};

    assign w_pp0 = w_a_lo * w_b_lo;
    assign w_pp1 = w_a_lo * w_b_hi;
    assign w_pp2 = w_a_hi * w_b_lo;
    assign w_pp3 = w_a_hi * w_b_hi;

    logic [c_pw-1:0]  r_pp0;
    logic [c_pw-1:0]  r_pp1;
    logic [c_pw-1:0]  r_pp2;
    logic [c_pw-1:0]  r_pp3;
    logic [1:0]       r_s1_mode;
    logic [TAG_W-1:0] r_s1_tag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_pp0      <= '0;
            r_pp1      <= '0;
            r_pp2      <= '0;
            r_pp3      <= '0;
            r_s1_mode  <= 2'b00;
            r_s1_tag   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_pp0     <= w_pp0;
                r_pp1     <= w_pp1;
                r_pp2     <= w_pp2;
                r_pp3     <= w_pp3;
                r_s1_mode <= in_mode;
                r_s1_tag  <= in_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: recombination, optional accumulate, word select
    // ------------------------------------------------------------------
    logic [c_fw-1:0]   w_e0;
    logic [c_fw-1:0]   w_e1;
    logic [c_fw-1:0]   w_e2;
    logic [c_fw-1:0]   w_e3;
    logic [c_fw-1:0]   w_p;
    logic [c_fw-1:0]   w_sel;
    logic [DATA_W-1:0] w_word;

    assign w_e0 = {{(c_fw-c_pw){r_pp0[c_pw-1]}}, r_pp0};
    assign w_e1 = {{(c_fw-c_pw){r_pp1[c_pw-1]}}, r_pp1};
    assign w_e2 = {{(c_fw-c_pw){r_pp2[c_pw-1]}}, r_pp2};
    assign w_e3 = {{(c_fw-c_pw){r_pp3[c_pw-1]}}, r_pp3};
    assign w_p  = w_e0 + ((w_e1 + w_e2) << c_h) + (w_e3 << DATA_W);

`ifdef MULT_PIPE_ACC_EN
    logic            r_s1_acc;
    logic            r_s1_acc_clr;
    logic [c_fw-1:0] r_acc;
    logic [c_fw-1:0] w_acc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_acc     <= 1'b0;
            r_s1_acc_clr <= 1'b0;
        end else if (w_s1_adv && in_valid) begin
            r_s1_acc     <= in_acc;
            r_s1_acc_clr <= in_acc_clr;
        end
    end

    assign w_acc_next = (r_s1_acc_clr ? {c_fw{1'b0}} : r_acc) + w_p;
    assign w_sel      = r_s1_acc ? w_acc_next : w_p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (w_s2_adv && r_s1_valid && r_s1_acc) begin
            r_acc <= w_acc_next;
        end
    end
`else
    assign w_sel = w_p;
`endif

    assign w_word = (r_s1_mode == 2'b00) ? w_sel[DATA_W-1:0] : w_sel[c_fw-1:DATA_W];

    logic [DATA_W-1:0] r_result;
    logic [TAG_W-1:0]  r_out_tag;

    // Result registers only load when a real operation moves in, so they
    // hold across stalls and bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_out_tag  <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result  <= w_word;
                r_out_tag <= r_s1_tag;
            end
        end
    end

    assign out_result = r_result;
    assign out_tag    = r_out_tag;

endmodule
`default_nettype wire

// File: doc/mult_pipe_cell.md
Name: mult_pipe_cell

Overview:
Parametrised, elastic two-stage multiplier for the CPU execute/memory path. It is the successor to the fixed 16x16 partial-product cell. It forms all four half-width partial products, sums them, and returns the full 2*DATA_W product. The result is returned as the low or high word, with unsigned, signed or mixed-sign operands. A valid/ready handshake on each side replaces the single stage-enable signal, so the block tolerates back-pressure from the writeback stage.

Parameters:
DATA_W, 32, operand and result width; must be even and >= 8; H = DATA_W/2.
TAG_W, 4, width of the sideband tag carried alongside each operation (destination register id).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous reset, active-high.
in_valid  in  1  operation offered.
in_ready  out  1  operation accepted when in_valid & in_ready.
in_a  in  DATA_W  operand A.
in_b  in  DATA_W  operand B.
in_mode  in  2  00 MUL (low word), 01 MULXUU, 10 MULXSU (A signed, B unsigned), 11 MULXSS; modes 01/10/11 return the high word.
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  result available.
out_ready  in  1  result consumed when out_valid & out_ready.
out_result  out  DATA_W  selected product word.
out_tag  out  TAG_W  tag of the operation.
busy  out  1  either pipeline stage holds a valid operation.

Behaviour:
- Reset (asynchronous, active-high): clear s1_valid, s2_valid, out_result, out_tag and all pipeline data to 0. in_ready = 1 once reset is deasserted.
- Reset mid-operation: all in-flight operations are discarded. No output is produced for them.
- Stage S1 (register): stores the four partial products, mode and tag.
  - pp0 = A[H-1:0] * B[H-1:0]
  - pp1 = A[H-1:0] * B[DATA_W-1:H]
  - pp2 = A[DATA_W-1:H] * B[H-1:0]
  - pp3 = A[DATA_W-1:H] * B[DATA_W-1:H]
  - Upper halves are sign-extended to H+1 bits when that operand is signed: A in modes 10 and 11, B in mode 11. Low halves are always unsigned.
- Stage S2 (register): computes P = pp0 + (pp1 + pp2) << H + pp3 << DATA_W, modulo 2^(2*DATA_W).
  - P must equal the exact two's-complement product of the operands as interpreted by the mode.
  - out_result = P[DATA_W-1:0] for mode 00, otherwise P[2*DATA_W-1:DATA_W].
  - out_result and out_tag are registered and hold stable while out_valid & ~out_ready.
- Handshake: s2_adv = ~s2_valid | out_ready; s1_adv = ~s1_valid | s2_adv; in_ready = s1_adv.
  - in_ready is combinational from out_ready. There is no combinational path from in_* data to out_*.
- Latency and throughput: latency is exactly 2 cycles from acceptance to out_valid when out_ready = 1. Throughput is 1 operation per cycle.
- Capacity and ordering: 2 operations in flight. Order is strictly preserved.
- Full pipeline: with out_ready = 0 and both stages valid, in_ready = 0. Stages hold their data unchanged.
- Simultaneous accept and consume on a full pipeline: both stages shift in the same cycle. No bubble is inserted and no operation is lost.
- Empty pipeline: out_valid = 0. out_result holds its last value, which is not meaningful.
- busy = s1_valid | s2_valid.
- Mode decode: all in_mode values are legal. There is no error path.

Optional Feature:
Macro MULT_PIPE_ACC_EN.
- Defined:
  - Adds ports in_acc (in, 1) and in_acc_clr (in, 1), sampled with the operation.
  - Adds a 2*DATA_W accumulator register, reset to 0.
  - When an operation with in_acc = 1 advances out of S1:
    - acc_next = (in_acc_clr ? 0 : acc) + P, modulo 2^(2*DATA_W).
    - acc is updated to acc_next.
    - out_result selects the low or high word from acc_next instead of P.
  - Operations with in_acc = 0 leave acc untouched.
  - The accumulation must be computed in S2. Latency and throughput are unchanged.
- Not defined: ports and accumulator are absent. Behaviour is exactly as above.

Test Plan:
- Modes at DATA_W=32, A=B=0xFFFFFFFF, out_ready=1 -> expected out_result per mode, each 2 cycles after acceptance:
  - mode 00 -> 0x00000001
  - mode 01 -> 0xFFFFFFFE
  - mode 10 -> 0xFFFFFFFF
  - mode 11 -> 0x00000000
- Extreme signed: A=B=0x80000000, mode 11 -> 0x40000000; same operands, mode 00 -> 0x00000000.
- Back-to-back: accept tags 1, 2, 3 on consecutive cycles with out_ready=1 -> out_valid for 3 consecutive cycles, tags 1, 2, 3, first result 2 cycles after the first acceptance.
- Back-pressure: out_ready=0, offer 3 ops -> exactly 2 accepted, then in_ready=0. out_result holds its value. Raising out_ready for 1 cycle accepts the 3rd op in that same cycle, and all results arrive in order.
- Reset mid-operation: assert reset with 2 ops in flight -> out_valid=0, busy=0, out_result=0 immediately, asynchronously. No stale result appears after release.
- MULT_PIPE_ACC_EN, mode 00:
  - 3*4 with in_acc=1, in_acc_clr=1 -> 12
  - then 5*6 with in_acc=1, in_acc_clr=0 -> 42
  - then 2*2 with in_acc=0 -> 4, accumulator still 42
  - then 1*1 with in_acc=1, in_acc_clr=0 -> 43
